// File: rtl/bidin_ctrl.sv
// -----------------------------------------------------------------------------
// bidin_ctrl
// Block deinterleaver controller built around one external single-port SRAM.
// A frame of ROWS*COLS soft bits is written row-major (addresses 0..N-1 in
// arrival order). The frame is then read back column-major and streamed out.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_vld/in_sof/in_data   input stream; in_sof marks the first sample
//   in_rdy                  high while the block can take input (IDLE, FILL)
//   out_vld/out_rdy         output handshake
//   out_data/out_last       deinterleaved soft bit, final-beat marker
//   err_resync              one-cycle pulse when in_sof arrives mid-frame
//   sram_a/cen/wen/d/q      single-port SRAM; cen/wen active-low, q one cycle
//                           after a read and held until the next read
// -----------------------------------------------------------------------------
module bidin_ctrl #(
    parameter int ROWS  = 240,
    parameter int COLS  = 612,
    parameter int A_WID = 18,
    parameter int D_WID = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic             in_sof,
    input  logic [D_WID-1:0] in_data,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [D_WID-1:0] out_data,
    output logic             out_last,
    output logic             err_resync,
    output logic [A_WID-1:0] sram_a,
    output logic             sram_cen,
    output logic             sram_wen,
    output logic [D_WID-1:0] sram_d,
    input  logic [D_WID-1:0] sram_q
);

    localparam int N     = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [A_WID-1:0] LAST_ADDR = A_WID'(N - 1);
    localparam logic [A_WID-1:0] COLS_A    = A_WID'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [A_WID-1:0]   wr_addr_q, wr_addr_d;
    logic [A_WID-1:0]   rd_addr_q, rd_addr_d;
    logic [ROW_W-1:0]   rd_row_q, rd_row_d;
    logic [COL_W-1:0]   rd_col_q, rd_col_d;
    logic               out_vld_q, out_vld_d;
    logic               out_last_q, out_last_d;
    logic               err_q, err_d;
    logic [A_WID-1:0]   sram_a_q, sram_a_d;
    logic [D_WID-1:0]   sram_d_q, sram_d_d;

    logic               in_rdy_s;
    logic               accept_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               rd_last_s;
    logic [A_WID-1:0]   addr_s;
    logic [D_WID-1:0]   wdata_s;

    // rst_n is folded in so the port reads 0 while reset is held.
    assign in_rdy_s  = rst_n & (state_q != S_DRAIN);
    assign accept_s  = in_vld & in_rdy_s;
    assign rd_last_s = (rd_row_q == ROW_LAST) && (rd_col_q == COL_LAST);

    // Next-state, SRAM access decode and address stepping.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        err_d      = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        // Address/data hold their last value whenever the SRAM is idle.
        addr_s     = sram_a_q;
        wdata_s    = sram_d_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s && in_sof) begin
                    wr_en_s   = 1'b1;
                    addr_s    = '0;
                    wdata_s   = in_data;
                    wr_addr_d = A_WID'(1);
                    state_d   = S_FILL;
                end else begin
                    // Samples outside a frame are dropped without SRAM access.
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    wdata_s = in_data;
                    if (in_sof) begin
                        // Restart the frame at address 0 and flag the resync.
                        addr_s    = '0;
                        wr_addr_d = A_WID'(1);
                        err_d     = 1'b1;
                    end else if (wr_addr_q == LAST_ADDR) begin
                        addr_s    = wr_addr_q;
                        wr_addr_d = '0;
                        rd_addr_d = '0;
                        rd_row_d  = '0;
                        rd_col_d  = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        addr_s    = wr_addr_q;
                        wr_addr_d = wr_addr_q + A_WID'(1);
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DRAIN: begin
                // A read is issued only when the output register is free or
                // being emptied this cycle, so sram_q is never overwritten
                // while a beat is still waiting.
                if (!out_vld_q || out_rdy) begin
                    rd_en_s = 1'b1;
                    addr_s  = rd_addr_q;
                    if (rd_last_s) begin
                        rd_addr_d = '0;
                        rd_row_d  = '0;
                        rd_col_d  = '0;
                        state_d   = S_IDLE;
                    end else if (rd_row_q != ROW_LAST) begin
                        // Next row of the same column: step by one row stride.
                        rd_addr_d = rd_addr_q + COLS_A;
                        rd_row_d  = rd_row_q + ROW_W'(1);
                    end else begin
                        // Top of the next column is simply its column index.
                        rd_row_d  = '0;
                        rd_col_d  = rd_col_q + COL_W'(1);
                        rd_addr_d = A_WID'(rd_col_q) + A_WID'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output register: set one cycle after a read, cleared on a take
        // without a fresh read; the last beat survives the move to IDLE.
        if (rd_en_s) begin
            out_vld_d  = 1'b1;
            out_last_d = rd_last_s;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end else begin
            out_vld_d  = out_vld_q;
            out_last_d = out_last_q;
        end

        sram_a_d = addr_s;
        sram_d_d = wdata_s;
    end

    // State, counters and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
            sram_a_q   <= '0;
            sram_d_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
            sram_a_q   <= sram_a_d;
            sram_d_q   <= sram_d_d;
        end
    end

    assign in_rdy     = in_rdy_s;
    assign sram_cen   = ~(rst_n & (wr_en_s | rd_en_s));
    assign sram_wen   = ~(rst_n & wr_en_s);
    assign sram_a     = addr_s;
    assign sram_d     = wdata_s;
    assign out_vld    = out_vld_q;
    assign out_last   = out_last_q;
    assign out_data   = sram_q;
    assign err_resync = err_q;

endmodule

// File: tb/tb_bidin_ctrl.sv
module tb_bidin_ctrl;

    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int A_WID = 4;
    localparam int D_WID = 6;
    localparam int N     = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vld = 1'b0;
    logic             in_sof = 1'b0;
    logic [D_WID-1:0] in_data = '0;
    logic             in_rdy;
    logic             out_vld;
    logic             out_rdy = 1'b1;
    logic [D_WID-1:0] out_data;
    logic             out_last;
    logic             err_resync;
    logic [A_WID-1:0] sram_a;
    logic             sram_cen;
    logic             sram_wen;
    logic [D_WID-1:0] sram_d;
    logic [D_WID-1:0] sram_q = '0;

    bidin_ctrl #(.ROWS(ROWS), .COLS(COLS), .A_WID(A_WID), .D_WID(D_WID)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_last(out_last), .err_resync(err_resync),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial forever #5 clk = ~clk;

    // Single-port SRAM model: q updates only on reads.
    logic [D_WID-1:0] mem [0:(1<<A_WID)-1];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference model: the written frame and the column-major expectation.
    typedef struct packed {logic [D_WID-1:0] d; logic last;} beat_t;
    beat_t            exp_q[$];
    logic [D_WID-1:0] frame [N];
    int               beats   = 0;
    int               err_cnt = 0;

    task automatic push_expected();
        for (int k = 0; k < N; k++) begin
            beat_t b;
            b.d    = frame[(k % ROWS) * COLS + (k / ROWS)];
            b.last = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    // Output monitor and scoreboard.
    initial begin
        logic             prev_stall = 1'b0;
        logic [D_WID-1:0] prev_d = '0;
        logic             prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_vld",  32'(out_vld),  32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_d));
                    check("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (err_resync) err_cnt++;
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d_data", beats), 32'(out_data), 32'(e.d));
                        check($sformatf("beat%0d_last", beats), 32'(out_last), 32'(e.last));
                        beats++;
                    end
                end
                prev_stall = out_vld && !out_rdy;
                prev_d     = out_data;
                prev_last  = out_last;
            end
        end
    end

    // out_rdy pattern: 0 = always ready, 1 = toggle, else random.
    int rdy_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ~out_rdy;
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input logic [D_WID-1:0] d, input logic sof, input bit gaps);
        int cnt;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                in_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_vld  = 1'b1;
        in_sof  = sof;
        in_data = d;
        cnt = 0;
        @(negedge clk);
        while (!in_rdy && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_rdy) fail_now("in_rdy_timeout");
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        push_expected();
        for (int j = 0; j < N; j++) send(frame[j], (j == 0), gaps);
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 600) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    typedef struct {
        logic             vld, sof;
        logic [D_WID-1:0] d;
        logic             rdy, cen, wen;
        logic [A_WID-1:0] a;
        logic [D_WID-1:0] wd;
    } vec_t;
    vec_t vt[17];

    initial begin
        int base, cnt;

        // Discards, frame start, a write gap, fill to the end, first read.
        vt[0] = '{1'b1, 1'b0, 6'd5, 1'b1, 1'b1, 1'b1, 4'd0, 6'd0};
        vt[1] = '{1'b1, 1'b0, 6'd6, 1'b1, 1'b1, 1'b1, 4'd0, 6'd0};
        vt[2] = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 4'd0, 6'd0};
        vt[3] = '{1'b1, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0};
        vt[4] = '{1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 4'd1, 6'd1};
        vt[5] = '{1'b0, 1'b0, 6'd9, 1'b1, 1'b1, 1'b1, 4'd1, 6'd1};
        for (int i = 2; i < N; i++)
            vt[4 + i] = '{1'b1, 1'b0, 6'(i), 1'b1, 1'b0, 1'b0, 4'(i), 6'(i)};
        vt[16] = '{1'b1, 1'b0, 6'd7, 1'b0, 1'b0, 1'b1, 4'd0, 6'd11};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_in_rdy",   32'(in_rdy),     32'd0);
        check("rst_cen",      32'(sram_cen),   32'd1);
        check("rst_wen",      32'(sram_wen),   32'd1);
        check("rst_out_vld",  32'(out_vld),    32'd0);
        check("rst_out_last", 32'(out_last),   32'd0);
        check("rst_err",      32'(err_resync), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Table-driven frame 0..11 with out_rdy held high.
        for (int j = 0; j < N; j++) frame[j] = 6'(j);
        push_expected();
        for (int i = 0; i < 17; i++) begin
            in_vld  = vt[i].vld;
            in_sof  = vt[i].sof;
            in_data = vt[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_rdy", i), 32'(in_rdy),   32'(vt[i].rdy));
            check($sformatf("vec%0d_cen", i), 32'(sram_cen), 32'(vt[i].cen));
            check($sformatf("vec%0d_wen", i), 32'(sram_wen), 32'(vt[i].wen));
            check($sformatf("vec%0d_a", i),   32'(sram_a),   32'(vt[i].a));
            check($sformatf("vec%0d_d", i),   32'(sram_d),   32'(vt[i].wd));
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        wait_drain();
        @(negedge clk);
        check("rdy_after_frame", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Back-pressure toggling every cycle.
        rdy_mode = 1;
        for (int j = 0; j < N; j++) frame[j] = 6'(20 + j);
        send_frame(1'b0);
        wait_drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Mid-frame resync after six samples.
        err_cnt = 0;
        for (int j = 0; j < 6; j++) send(6'(40 + j), (j == 0), 1'b0);
        for (int j = 0; j < N; j++) frame[j] = 6'(50 + j);
        send_frame(1'b0);
        wait_drain();
        check("resync_pulses", 32'(err_cnt), 32'd1);

        // Reset during drain after five outputs, then a clean frame.
        base = beats;
        for (int j = 0; j < N; j++) frame[j] = 6'(2 * j + 1);
        send_frame(1'b0);
        cnt = 0;
        while (beats < base + 5 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (beats < base + 5) fail_now("drain_start_timeout");
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_vld", 32'(out_vld),  32'd1 - 32'd1);
        check("midrst_cen",     32'(sram_cen), 32'd1);
        check("midrst_in_rdy",  32'(in_rdy),   32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) frame[j] = 6'(63 - j);
        send_frame(1'b0);
        wait_drain();

        // Randomized frames, gaps, junk before sof, random back-pressure.
        rdy_mode = 2;
        err_cnt  = 0;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                send(6'($urandom), 1'b0, 1'b1);
                send(6'($urandom), 1'b0, 1'b1);
            end
            for (int j = 0; j < N; j++) frame[j] = 6'($urandom);
            send_frame(1'b1);
        end
        wait_drain();
        check("random_no_resync", 32'(err_cnt), 32'd0);
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bidin_ctrl.md
BIDIN_CTRL -- requirements
Module: bidin_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 240, matrix rows.
REQ-002 SHALL have parameter COLS, default 612, matrix columns; N = ROWS*COLS = 146880 entries per frame.
REQ-003 SHALL have parameter A_WID, default 18, SRAM address width.
REQ-004 SHALL have parameter D_WID, default 6, soft-bit width.
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge; reset is asynchronous and active-low.
  rst_n  in  1  asynchronous active-low reset.
  in_vld  in  1  input sample valid.
  in_sof  in  1  first sample of frame, qualified by in_vld.
  in_data  in  D_WID  input soft bit.
  in_rdy  out  1  block accepts input.
  out_vld  out  1  output sample valid.
  out_rdy  in  1  downstream accepts output.
  out_data  out  D_WID  deinterleaved soft bit.
  out_last  out  1  marks final sample of frame, qualified by out_vld.
  err_resync  out  1  one-cycle pulse on mid-frame in_sof.
  sram_a  out  A_WID  SRAM address.
  sram_cen  out  1  SRAM chip enable, active-low.
  sram_wen  out  1  SRAM write enable, active-low (1 = read).
  sram_d  out  D_WID  SRAM write data.
  sram_q  in  D_WID  SRAM read data, valid the cycle after a read; holds until the next read.

Function
REQ-006 SHALL implement states IDLE, FILL and DRAIN over one single-port SRAM: row-major write, column-major read.
REQ-007 in_rdy SHALL be 1 in IDLE and FILL and 0 in DRAIN; accept = in_vld & in_rdy.
REQ-008 IDLE: accepts without in_sof SHALL be discarded, with no SRAM access; an accept with in_sof SHALL write address 0, set wr_addr=1 and go to FILL.
REQ-009 FILL: each accept SHALL write in_data to sram_a=wr_addr in the same cycle (sram_cen=0, sram_wen=0, sram_d=in_data), then increment wr_addr.
REQ-010 FILL: an accept with in_sof SHALL write address 0, set wr_addr=1 and pulse err_resync for one cycle.
REQ-011 The write to address N-1 SHALL move FILL to DRAIN and clear the read counters (rd_row=0, rd_col=0, rd_addr=0).
REQ-012 DRAIN: issue a read (sram_cen=0, sram_wen=1, sram_a=rd_addr) in a cycle when (!out_vld | out_rdy); otherwise sram_cen=1.
REQ-013 Read address stepping SHALL use no multiplier: rd_row<ROWS-1 -> rd_addr+=COLS, rd_row+1; else rd_row=0, rd_col+1, rd_addr=rd_col+1.
REQ-014 out_vld SHALL be set the cycle after a read issue and clear on out_rdy without a new issue; out_data SHALL equal sram_q combinationally.
REQ-015 out_last SHALL be set with the beat read from address N-1 (rd_row=ROWS-1, rd_col=COLS-1).
REQ-016 Issuing the last read SHALL move DRAIN to IDLE in the next cycle; the pending last beat SHALL remain valid and unchanged, because writes do not disturb sram_q.
REQ-017 Throughput SHALL be one write per cycle in FILL, and one output per cycle in DRAIN while out_rdy=1; read-issue-to-out_vld latency SHALL be 1 cycle.
REQ-018 When the SRAM is idle, sram_cen SHALL be 1, sram_wen SHALL be 1, and sram_a/sram_d SHALL hold their last values.
REQ-019 wr_addr and rd_addr SHALL never exceed N-1.

Reset
REQ-020 While rst_n=0, all registers SHALL clear asynchronously: state=IDLE, counters=0, out_vld=0, out_last=0, err_resync=0.
REQ-021 While rst_n=0, the outputs SHALL be forced to sram_cen=1, sram_wen=1 and in_rdy=0.
REQ-022 Reset mid-FILL or mid-DRAIN SHALL abandon the frame; SRAM contents need not be cleared.
REQ-023 After release, the block SHALL wait for in_sof.

Verification
REQ-024 ROWS=3, COLS=4; frame values 0..11 streamed with out_rdy=1 -> out_data 0,4,8,1,5,9,2,6,10,3,7,11; out_last only on 11; then in_rdy=1.
REQ-025 Samples 5,6 without in_sof, then frame with sof -> 5,6 not written (sram_cen=1); output as REQ-024.
REQ-026 Frame 0..11, out_rdy toggling 1/0 each cycle -> identical sequence, no duplicates/drops, out_data stable while out_vld & !out_rdy.
REQ-027 in_sof at sample 6 of FILL -> err_resync single pulse; following 12 samples form the frame; output matches them.
REQ-028 rst_n low during DRAIN after 5 outputs -> out_vld=0, sram_cen=1 immediately; new frame after release deinterleaves correctly.
REQ-029 Default params: full 146880-sample frame -> first outputs addresses 0,612,1224; last beat address 146879 with out_last=1.
